uart_cmd_slave: RTL

Responder end of the two-byte command UART link; it is the slave-side counterpart to the command master. It deserializes RX bytes, assembles them into a 16-bit command (high byte first, then low byte) and flags it to the core with a ready/clear handshake. It also serializes an 8-bit response back onto TX on request. RX/TX bit engines are self-contained: 8N1 framing, LSB first, line idles high.

---
 rtl/uart_cmd_slave.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_slave.sv
// Slave end of the two-byte command UART link.
// The RX path rebuilds a 16-bit command, high byte first, and raises cmd_rdy until the core
// clears it. The TX path serializes one response byte on request.
// Framing is 8N1, LSB first, and the line idles high.
module uart_cmd_slave #(
    parameter int unsigned BAUD_CYCLES    = 2604,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent
);

    localparam int unsigned BW = $clog2(BAUD_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BW-1:0] BaudFull  = BW'(BAUD_CYCLES);
    localparam logic [BW-1:0] BaudHalf  = BW'(BAUD_CYCLES / 2);
    localparam logic [BW-1:0] TxReload  = BW'(BAUD_CYCLES - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {RxIdle, RxRecv}           rx_state_e;
    typedef enum logic {AsmWaitHigh, AsmWaitLow}  asm_state_e;
    typedef enum logic {TxIdle, TxSend}           tx_state_e;

    logic            rx_meta, rx_sync, rx_prev;
    rx_state_e       rx_state;
    logic [BW-1:0]   rx_cnt;
    logic [3:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            byte_done;
    logic            frame_err;

    asm_state_e      asm_state;
    logic [7:0]      high_byte;
    logic [TW-1:0]   to_cnt;

    tx_state_e       tx_state;
    logic [8:0]      tx_shift;
    logic [BW-1:0]   tx_cnt;
    logic [3:0]      tx_bit;

    // Double-flop the asynchronous RX line; rx_prev feeds falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX bit engine: samples mid-bit, emits one-cycle byte_done or frame_err pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RxIdle;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RxIdle: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RxRecv;
                        rx_cnt   <= BaudHalf;
                        rx_bit   <= '0;
                    end
                end
                RxRecv: begin
                    if (rx_cnt == BW'(1)) begin
                        rx_cnt <= BaudFull;
                        rx_bit <= rx_bit + 4'd1;
                        if (rx_bit == 4'd0) begin
                            // A high line at mid-start means the edge was a glitch.
                            if (rx_sync) begin
                                rx_state <= RxIdle;
                            end
                        end else if (rx_bit == 4'd9) begin
                            rx_state <= RxIdle;
                            if (rx_sync) begin
                                byte_done <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            rx_shift <= {rx_sync, rx_shift[7:1]};
                        end
                    end else begin
                        rx_cnt <= rx_cnt - BW'(1);
                    end
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

    // Command assembler: pairs bytes, drops a stale high byte, and owns cmd and cmd_rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state <= AsmWaitHigh;
            high_byte <= '0;
            to_cnt    <= '0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
            if (frame_err) begin
                asm_state <= AsmWaitHigh;
            end else begin
                case (asm_state)
                    AsmWaitHigh: begin
                        if (byte_done) begin
                            high_byte <= rx_shift;
                            cmd_rdy   <= 1'b0;
                            to_cnt    <= '0;
                            asm_state <= AsmWaitLow;
                        end
                    end
                    AsmWaitLow: begin
                        // byte_done is checked first so it beats a coincident timeout.
                        if (byte_done) begin
                            cmd       <= {high_byte, rx_shift};
                            cmd_rdy   <= 1'b1;
                            asm_state <= AsmWaitHigh;
                        end else if (to_cnt == TimeoutLast) begin
                            high_byte <= '0;
                            asm_state <= AsmWaitHigh;
                        end else begin
                            to_cnt <= to_cnt + TW'(1);
                        end
                    end
                    default: asm_state <= AsmWaitHigh;
                endcase
            end
        end
    end

    // TX engine: shifts {resp, start} out LSB first and fills with ones, so the stop bit and
    // the idle level come out high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TxIdle;
            tx_shift  <= '1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_busy   <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            case (tx_state)
                TxIdle: begin
                    if (send_resp) begin
                        tx_shift  <= {resp, 1'b0};
                        tx_cnt    <= TxReload;
                        tx_bit    <= '0;
                        tx_busy   <= 1'b1;
                        resp_sent <= 1'b0;
                        tx_state  <= TxSend;
                    end
                end
                TxSend: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= TxReload;
                        if (tx_bit == 4'd9) begin
                            tx_busy   <= 1'b0;
                            resp_sent <= 1'b1;
                            tx_state  <= TxIdle;
                        end else begin
                            tx_shift <= {1'b1, tx_shift[8:1]};
                            tx_bit   <= tx_bit + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - BW'(1);
                    end
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

    assign TX = tx_shift[0];

endmodule
